// File: rtl/ir_nec_receiver_if.sv
// ir_nec_receiver_if: IR line input and decoded-frame outputs of the NEC receiver
// Signals: ir_input_data (raw line), ir_data_out (held frame), frame_valid,
//          repeat_valid, frame_error (one-cycle pulses), busy (decoder active).
interface ir_nec_receiver_if #(
    parameter int FRAME_BITS = 32
);
    logic                  ir_input_data;
    logic [FRAME_BITS-1:0] ir_data_out;
    logic                  frame_valid;
    logic                  repeat_valid;
    logic                  frame_error;
    logic                  busy;
    modport master (
        input  ir_input_data,
        output ir_data_out, frame_valid, repeat_valid, frame_error, busy
    );
    modport slave (
        output ir_input_data,
        input  ir_data_out, frame_valid, repeat_valid, frame_error, busy
    );
endinterface

// File: rtl/ir_nec_receiver.sv
// ir_nec_receiver: NEC-style pulse-distance IR frame decoder with repeat and error flags
// Ports: osc_clk (clock), reset (sync, active-high), bus.ir_input_data (async IR line),
//        bus.ir_data_out (last good frame), bus.frame_valid / bus.repeat_valid /
//        bus.frame_error (one-cycle pulses), bus.busy (state not IDLE).
module ir_nec_receiver #(
    parameter int TICK_DIV         = 500,
    parameter int FRAME_BITS       = 32,
    parameter int ACTIVE_LOW       = 1,
    parameter int CHECK_INV        = 1,
    parameter int CNT_W            = 12,
    parameter int LEAD_MARK_MIN    = 800,
    parameter int LEAD_SPACE_MIN   = 350,
    parameter int LEAD_SPACE_MAX   = 600,
    parameter int REPEAT_SPACE_MIN = 150,
    parameter int BIT_MARK_MAX     = 100,
    parameter int BIT_SPACE_THRESH = 112,
    parameter int TIMEOUT          = 250
) (
    input  logic              osc_clk,
    input  logic              reset,
    ir_nec_receiver_if.master bus
);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] C_LMM = CNT_W'(LEAD_MARK_MIN);
    localparam logic [CNT_W-1:0] C_LSM = CNT_W'(LEAD_SPACE_MIN);
    localparam logic [CNT_W-1:0] C_LSX = CNT_W'(LEAD_SPACE_MAX);
    localparam logic [CNT_W-1:0] C_RSM = CNT_W'(REPEAT_SPACE_MIN);
    localparam logic [CNT_W-1:0] C_BMX = CNT_W'(BIT_MARK_MAX);
    localparam logic [CNT_W-1:0] C_BST = CNT_W'(BIT_SPACE_THRESH);
    localparam logic [CNT_W-1:0] C_TO  = CNT_W'(TIMEOUT);
    localparam logic [1:0] IDLE_SYNC   = (ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

    typedef enum logic [2:0] {S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_STOP} state_t;

    state_t                r_state, w_next;
    logic [1:0]            r_sync;
    logic [TW-1:0]         r_tick_cnt;
    logic                  r_level;
    logic [CNT_W-1:0]      r_cnt;
    logic [BW-1:0]         r_bits;
    logic [FRAME_BITS-2:0] r_sr;
    logic [FRAME_BITS-1:0] r_data, w_sr_next;
    logic                  r_have, r_fv, r_rv, r_fe;
    logic                  w_tick, w_mark, w_edge, w_last, w_inv_ok;
    logic                  w_fv, w_rv, w_fe, w_shift, w_clr;

    assign w_tick    = r_tick_cnt == TW'(TICK_DIV - 1);
    assign w_mark    = (ACTIVE_LOW != 0) ? ~r_sync[1] : r_sync[1];
    assign w_edge    = w_mark != r_level;
    assign w_last    = r_bits == BW'(FRAME_BITS - 1);
    // Only FRAME_BITS-1 bits need storing: the newest bit enters at the MSB of w_sr_next.
    assign w_sr_next = {r_cnt > C_BST, r_sr};

    generate
        if (CHECK_INV != 0 && FRAME_BITS == 32) begin : g_inv
            assign w_inv_ok = (w_sr_next[15:8] == ~w_sr_next[7:0]) && (w_sr_next[31:24] == ~w_sr_next[23:16]);
        end else begin : g_noinv
            assign w_inv_ok = 1'b1;
        end
    endgenerate

    always_ff @(posedge osc_clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Limit checks come before edge evaluation so an over-long level errors even on its closing edge.
    always_comb begin
        w_next  = r_state;
        w_fv    = 1'b0;
        w_rv    = 1'b0;
        w_fe    = 1'b0;
        w_shift = 1'b0;
        w_clr   = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_IDLE:      if (w_edge && w_mark) w_next = S_LEAD_MARK;
                S_LEAD_MARK: if (w_edge) w_next = (r_cnt < C_LMM) ? S_IDLE : S_LEAD_SPACE;
                S_LEAD_SPACE: begin
                    if (r_cnt > C_LSX) w_fe = 1'b1;
                    else if (w_edge) begin
                        w_fe   = r_cnt < C_RSM;
                        w_rv   = r_have && r_cnt >= C_RSM && r_cnt < C_LSM;
                        w_clr  = r_cnt >= C_LSM;
                        w_next = (r_cnt >= C_LSM) ? S_BIT_MARK : S_STOP;
                    end
                end
                S_BIT_MARK: begin
                    if (r_cnt > C_BMX) w_fe = 1'b1;
                    else if (w_edge) w_next = S_BIT_SPACE;
                end
                S_BIT_SPACE: begin
                    if (r_cnt > C_TO) w_fe = 1'b1;
                    else if (w_edge) begin
                        w_shift = 1'b1;
                        w_fv    = w_last && w_inv_ok;
                        w_fe    = w_last && !w_inv_ok;
                        w_next  = w_last ? S_STOP : S_BIT_MARK;
                    end
                end
                default: if (!w_mark) w_next = S_IDLE;
            endcase
            // A still-active mark is parked in STOP so it is not taken as a new leader.
            if (w_fe) w_next = w_mark ? S_STOP : S_IDLE;
        end
    end

    always_ff @(posedge osc_clk) begin
        if (reset) begin
            r_sync     <= IDLE_SYNC;
            r_tick_cnt <= '0;
            r_level    <= 1'b0;
            r_cnt      <= '0;
            r_bits     <= '0;
            r_sr       <= '0;
            r_data     <= '0;
            r_have     <= 1'b0;
            r_fv       <= 1'b0;
            r_rv       <= 1'b0;
            r_fe       <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], bus.ir_input_data};
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_fv       <= w_fv;
            r_rv       <= w_rv;
            r_fe       <= w_fe;
            if (w_tick) begin
                r_level <= w_mark;
                r_cnt   <= w_edge ? CNT_W'(1) : ((&r_cnt) ? r_cnt : r_cnt + 1'b1);
                if (w_clr) r_bits <= '0;
                if (w_shift) begin
                    r_sr   <= w_sr_next[FRAME_BITS-1:1];
                    r_bits <= r_bits + 1'b1;
                end
                if (w_fv) begin
                    r_data <= w_sr_next;
                    r_have <= 1'b1;
                end
                if (w_fe) r_have <= 1'b0;
            end
        end
    end

    assign bus.ir_data_out  = r_data;
    assign bus.frame_valid  = r_fv;
    assign bus.repeat_valid = r_rv;
    assign bus.frame_error  = r_fe;
    assign bus.busy         = r_state != S_IDLE;
endmodule

// File: tb/tb_ir_nec_receiver.sv
// tb_ir_nec_receiver: randomized segment-level checking of ir_nec_receiver against a frame model
module tb_ir_nec_receiver;
    localparam int TD  = 2;
    localparam int LMM = 80;
    localparam int LSM = 35;
    localparam int LSX = 60;
    localparam int RSM = 15;
    localparam int BMX = 10;
    localparam int BST = 11;
    localparam int TO  = 25;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ir_nec_receiver_if #(.FRAME_BITS(32)) bus();

    ir_nec_receiver #(
        .TICK_DIV(TD), .FRAME_BITS(32), .ACTIVE_LOW(1), .CHECK_INV(1), .CNT_W(12),
        .LEAD_MARK_MIN(LMM), .LEAD_SPACE_MIN(LSM), .LEAD_SPACE_MAX(LSX),
        .REPEAT_SPACE_MIN(RSM), .BIT_MARK_MAX(BMX), .BIT_SPACE_THRESH(BST), .TIMEOUT(TO)
    ) dut (
        .osc_clk(clk),
        .reset(rst),
        .bus(bus)
    );

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int n_fv = 0, n_rv = 0, n_fe = 0, n_multi = 0, fv_cyc = 0, fe_cyc = 0;
    int q[$];
    int st[$];
    bit rnd = 0;
    logic        m_have;
    logic [31:0] m_data;
    int e_fv, e_rv, e_fe;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.frame_valid) begin n_fv++; fv_cyc = cyc; end
        if (bus.repeat_valid) n_rv++;
        if (bus.frame_error) begin n_fe++; fe_cyc = cyc; end
        if (int'(bus.frame_valid) + int'(bus.repeat_valid) + int'(bus.frame_error) > 1) n_multi++;
    end

    function automatic logic [31:0] nec(logic [7:0] a, logic [7:0] c);
        return {~c, c, ~a, a};
    endfunction

    function automatic int r(int lo, int hi, int d);
        return rnd ? int'($urandom_range(hi, lo)) : d;
    endfunction

    // q holds alternating mark/space durations in ticks, starting with a mark.
    task automatic add_frame(logic [31:0] d, int nbits);
        q.push_back(r(80, 120, 90));
        q.push_back(r(35, 60, 45));
        for (int j = 0; j < nbits; j++) begin
            q.push_back(r(1, 10, 6));
            q.push_back(d[j] ? r(12, 25, 17) : r(1, 11, 6));
        end
    endtask

    task automatic add_full(logic [31:0] d);
        add_frame(d, 32);
        q.push_back(r(1, 20, 6));
        q.push_back(70);
    endtask

    task automatic add_rep();
        q.push_back(r(80, 120, 90));
        q.push_back(r(15, 34, 22));
        q.push_back(r(1, 20, 6));
        q.push_back(70);
    endtask

    task automatic merr();
        e_fe++;
        m_have = 1'b0;
    endtask

    // Walks the segment list frame by frame using the duration rules directly.
    task automatic model();
        int i, k, j;
        bit done;
        logic [31:0] d;
        e_fv = 0; e_rv = 0; e_fe = 0;
        i = 0;
        while (i + 1 < q.size()) begin
            if (q[i] < LMM) i += 2;
            else if (q[i+1] > LSX) begin merr(); i += 2; end
            else if (q[i+1] < RSM) begin merr(); i += 4; end
            else if (q[i+1] < LSM) begin if (m_have) e_rv++; i += 4; end
            else begin
                k = i + 2; j = 0; d = '0; done = 0;
                while (!done) begin
                    if (k + 1 >= q.size()) begin done = 1; i = k; end
                    else if (q[k] > BMX) begin merr(); done = 1; i = k + 2; end
                    else if (q[k+1] > TO) begin merr(); done = 1; i = k + 2; end
                    else begin
                        d[j] = q[k+1] > BST;
                        j++;
                        k += 2;
                        if (j == 32) begin
                            done = 1;
                            i = k + 2;
                            if (d[15:8] == ~d[7:0] && d[31:24] == ~d[23:16]) begin
                                m_have = 1'b1; m_data = d; e_fv++;
                            end else merr();
                        end
                    end
                end
            end
        end
    endtask

    task automatic send();
        st.delete();
        for (int s = 0; s < q.size(); s++) begin
            bus.ir_input_data = (s % 2 == 0) ? 1'b0 : 1'b1;
            st.push_back(cyc);
            repeat (q[s] * TD) @(negedge clk);
        end
        bus.ir_input_data = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic run(string tag);
        int f, rp, e;
        f = n_fv; rp = n_rv; e = n_fe;
        model();
        send();
        chk({tag, "_fv"}, n_fv - f, e_fv);
        chk({tag, "_rv"}, n_rv - rp, e_rv);
        chk({tag, "_fe"}, n_fe - e, e_fe);
        chk({tag, "_data"}, bus.ir_data_out, m_data);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_have = 1'b0;
        m_data = '0;
    endtask

    initial begin
        int kind, p, b, e;
        logic [31:0] d;
        bus.ir_input_data = 1'b1;
        m_have = 1'b0;
        m_data = '0;
        repeat (4) @(negedge clk);
        chk("rst_data", bus.ir_data_out, 0);
        chk("rst_fv", 32'(bus.frame_valid), 0);
        chk("rst_rv", 32'(bus.repeat_valid), 0);
        chk("rst_fe", 32'(bus.frame_error), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        add_full(nec(8'h00, 8'h40));
        run("t1");
        chk("t1_const", bus.ir_data_out, 32'hBF40FF00);
        chk("t1_lat", 32'(fv_cyc - st[66] >= 2 && fv_cyc - st[66] <= 5), 1);

        add_full(nec(8'h00, 8'h40));
        add_rep();
        run("t2");
        chk("t2_const", bus.ir_data_out, 32'hBF40FF00);

        add_full(32'hBE40FF00);
        add_rep();
        run("t3");
        chk("t3_const", bus.ir_data_out, 32'hBF40FF00);

        do_reset();
        repeat (10) @(negedge clk);
        add_rep();
        run("t2b");

        add_frame(nec(8'h5A, 8'hC3), 9);
        q.push_back(6);
        q.push_back(30);
        run("t4");
        chk("t4_tout", 32'(fe_cyc - st[21] >= 2 * TO && fe_cyc - st[21] <= 2 * TO + 8), 1);
        add_full(nec(8'h5A, 8'hC3));
        run("t4b");

        q.push_back(40);
        q.push_back(70);
        run("t5");
        add_frame(nec(8'h11, 8'h22), 5);
        q.push_back(12);
        q.push_back(70);
        run("t5b");

        add_frame(nec(8'h12, 8'h34), 20);
        q.push_back(6);
        e = n_fe;
        send();
        q.delete();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_data", bus.ir_data_out, 0);
        chk("t6_fv", 32'(bus.frame_valid), 0);
        chk("t6_rv", 32'(bus.repeat_valid), 0);
        chk("t6_fe", 32'(bus.frame_error), 0);
        chk("t6_busy", 32'(bus.busy), 0);
        rst = 1'b0;
        m_have = 1'b0;
        m_data = '0;
        repeat (140) @(negedge clk);
        chk("t6_nofe", n_fe - e, 0);
        add_full(nec(8'h12, 8'h34));
        run("t6b");

        rnd = 1;
        for (int it = 0; it < 12; it++) begin
            kind = $urandom_range(6, 0);
            d = nec(8'($urandom), 8'($urandom));
            p = $urandom_range(31, 0);
            case (kind)
                0: add_full(d);
                1: begin b = $urandom_range(31, 0); d[b] = ~d[b]; add_full(d); end
                2: add_rep();
                3: begin q.push_back($urandom_range(79, 1)); q.push_back(70); end
                4: begin add_frame(d, p); q.push_back($urandom_range(15, 11)); q.push_back(70); end
                5: begin add_frame(d, p); q.push_back(r(1, 10, 6)); q.push_back($urandom_range(40, 30)); end
                default: begin
                    q.push_back(r(80, 120, 90));
                    if ($urandom_range(1, 0) == 1) q.push_back($urandom_range(90, 61));
                    else begin
                        q.push_back($urandom_range(14, 1));
                        q.push_back(r(1, 20, 6));
                        q.push_back(70);
                    end
                end
            endcase
            run("rnd");
        end

        chk("exclusive", n_multi, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
